// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM stage: writeback source select, load/store
// width codes and the bus-access FSM states.
package lsu_pkg;

  localparam logic [1:0] ALU_RESULT = 2'b00;
  localparam logic [1:0] MEM_TO_REG = 2'b01;
  localparam logic [1:0] PC_PLUS    = 2'b10;
  localparam logic [1:0] LUI_AUIPC  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data bus: store enables/replication, load lane
// extraction with sign/zero extension, and natural-alignment checking.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // funct3[1:0] is the access size for both signed and unsigned variants
  always_comb begin
    be         = '0;
    wdata      = '0;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = |addr_lo;
      end
    endcase
  end

  always_comb begin
    lane_byte = '0;
    case (addr_lo)
      2'd0:    lane_byte = load_word[7:0];
      2'd1:    lane_byte = load_word[15:8];
      2'd2:    lane_byte = load_word[23:16];
      default: lane_byte = load_word[31:24];
    endcase
    lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_data = {24'd0, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data = {16'd0, lane_half};
      F3_W:    load_data = load_word;
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/stage_memory_lsu.sv
// MEM pipeline stage: issues loads/stores on a req/gnt/rvalid bus, stalls the
// front end while an access is outstanding, and registers the MEM->WB payload.
module stage_memory_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] execute_alu_result,
  input  logic [31:0] execute_wr_datamem_data,
  input  logic [2:0]  execute_funct3,
  input  logic        execute_datamem_wr_enable,
  input  logic [1:0]  execute_result_src,
  input  logic [4:0]  execute_rd,
  input  logic        execute_regfile_wr_enable,
  input  logic [31:0] execute_instr_addr_plus,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  mem_rd,
  output logic        mem_regfile_wr_enable,
  output logic [1:0]  mem_result_src,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_read_data,
  output logic [31:0] mem_instr_addr_plus,
  output logic        mem_fault
);

  lsu_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic [1:0]  rsrc_q;
  logic [31:0] pc4_q;

  logic        idle, mem_op, start, misalign, complete, timeout;
  logic [1:0]  sel_addr_lo;
  logic [2:0]  sel_funct3;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        al_mis;

  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [1:0]  wb_rsrc;
  logic [31:0] wb_alu, wb_rdata, wb_pc4;

  assign idle   = (state_q == IDLE);
  assign mem_op = execute_datamem_wr_enable | (execute_result_src == MEM_TO_REG);

  // One aligner serves both directions: IDLE looks at the incoming request,
  // busy states look at the captured one for load extraction.
  assign sel_addr_lo = idle ? execute_alu_result[1:0] : addr_q[1:0];
  assign sel_funct3  = idle ? execute_funct3 : funct3_q;

  lsu_align u_align (
    .addr_lo    (sel_addr_lo),
    .funct3     (sel_funct3),
    .store_data (execute_wr_datamem_data),
    .load_word  (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  assign start    = idle & mem_op & ~al_mis;
  assign misalign = idle & mem_op & al_mis;
  assign complete = ((state_q == REQ) & dmem_gnt & we_q) | ((state_q == WAIT) & dmem_rvalid);
  assign timeout  = ~idle & ~complete & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_stall = rst_n & (start | (~idle & ~complete & ~timeout));

  always_comb begin
    wb_rd    = '0;
    wb_wen   = 1'b0;
    wb_rsrc  = ALU_RESULT;
    wb_alu   = '0;
    wb_rdata = '0;
    wb_pc4   = '0;
    if (idle && !mem_op) begin
      wb_rd   = execute_rd;
      wb_wen  = execute_regfile_wr_enable;
      wb_rsrc = execute_result_src;
      wb_alu  = execute_alu_result;
      wb_pc4  = execute_instr_addr_plus;
    end else if (complete) begin
      wb_rd    = rd_q;
      wb_wen   = wen_q;
      wb_rsrc  = rsrc_q;
      wb_alu   = addr_q;
      wb_rdata = we_q ? '0 : al_load;
      wb_pc4   = pc4_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q               <= IDLE;
      cnt_q                 <= '0;
      addr_q                <= '0;
      funct3_q              <= '0;
      we_q                  <= 1'b0;
      rd_q                  <= '0;
      wen_q                 <= 1'b0;
      rsrc_q                <= ALU_RESULT;
      pc4_q                 <= '0;
      dmem_req              <= 1'b0;
      dmem_we               <= 1'b0;
      dmem_addr             <= '0;
      dmem_be               <= '0;
      dmem_wdata            <= '0;
      mem_rd                <= '0;
      mem_regfile_wr_enable <= 1'b0;
      mem_result_src        <= ALU_RESULT;
      mem_alu_result        <= '0;
      mem_read_data         <= '0;
      mem_instr_addr_plus   <= '0;
      mem_fault             <= 1'b0;
    end else begin
      mem_fault             <= misalign | timeout;
      mem_rd                <= wb_rd;
      mem_regfile_wr_enable <= wb_wen;
      mem_result_src        <= wb_rsrc;
      mem_alu_result        <= wb_alu;
      mem_read_data         <= wb_rdata;
      mem_instr_addr_plus   <= wb_pc4;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q     <= execute_alu_result;
            funct3_q   <= execute_funct3;
            we_q       <= execute_datamem_wr_enable;
            rd_q       <= execute_rd;
            wen_q      <= execute_regfile_wr_enable;
            rsrc_q     <= execute_result_src;
            pc4_q      <= execute_instr_addr_plus;
            dmem_req   <= 1'b1;
            dmem_we    <= execute_datamem_wr_enable;
            dmem_addr  <= {execute_alu_result[31:2], 2'b00};
            dmem_be    <= al_be;
            dmem_wdata <= execute_datamem_wr_enable ? al_wdata : '0;
            cnt_q      <= '0;
            state_q    <= REQ;
          end
        end
        REQ, WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (timeout || complete || ((state_q == REQ) && dmem_gnt)) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            state_q    <= (timeout || complete) ? IDLE : WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_memory_lsu.sv
// Directed bench for stage_memory_lsu with a writeback scoreboard and a
// cycle-level bus responder embedded in the issue task.
module tb_stage_memory_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] execute_alu_result, execute_wr_datamem_data, execute_instr_addr_plus;
  logic [2:0]  execute_funct3;
  logic        execute_datamem_wr_enable, execute_regfile_wr_enable;
  logic [1:0]  execute_result_src;
  logic [4:0]  execute_rd;
  logic        mem_stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [4:0]  mem_rd;
  logic        mem_regfile_wr_enable, mem_fault;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result, mem_read_data, mem_instr_addr_plus;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  rsrc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic        fault;
    logic        bubble;
  } wb_t;

  wb_t sb[$];
  bit  mon_en = 1'b0;
  bit  pend = 1'b0;

  always #5 clk = ~clk;

  stage_memory_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .execute_alu_result        (execute_alu_result),
    .execute_wr_datamem_data   (execute_wr_datamem_data),
    .execute_funct3            (execute_funct3),
    .execute_datamem_wr_enable (execute_datamem_wr_enable),
    .execute_result_src        (execute_result_src),
    .execute_rd                (execute_rd),
    .execute_regfile_wr_enable (execute_regfile_wr_enable),
    .execute_instr_addr_plus   (execute_instr_addr_plus),
    .mem_stall                 (mem_stall),
    .dmem_req                  (dmem_req),
    .dmem_we                   (dmem_we),
    .dmem_addr                 (dmem_addr),
    .dmem_be                   (dmem_be),
    .dmem_wdata                (dmem_wdata),
    .dmem_gnt                  (dmem_gnt),
    .dmem_rvalid               (dmem_rvalid),
    .dmem_rdata                (dmem_rdata),
    .mem_rd                    (mem_rd),
    .mem_regfile_wr_enable     (mem_regfile_wr_enable),
    .mem_result_src            (mem_result_src),
    .mem_alu_result            (mem_alu_result),
    .mem_read_data             (mem_read_data),
    .mem_instr_addr_plus       (mem_instr_addr_plus),
    .mem_fault                 (mem_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic wb_t mk(input logic [4:0] rd, input logic wen, input logic [1:0] rsrc,
                             input logic [31:0] alu, input logic [31:0] rdata,
                             input logic [31:0] pc4, input logic fault, input logic bubble);
    wb_t w;
    w.rd = rd; w.wen = wen; w.rsrc = rsrc; w.alu = alu;
    w.rdata = rdata; w.pc4 = pc4; w.fault = fault; w.bubble = bubble;
    return w;
  endfunction

  // A result appears one cycle after any non-stalled cycle
  always @(negedge clk) begin
    wb_t e;
    if (pend) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed=result expected=no_result");
      end else begin
        e = sb.pop_front();
        chk("wb_wen", 32'(mem_regfile_wr_enable), 32'(e.wen));
        chk("wb_rsrc", 32'(mem_result_src), 32'(e.rsrc));
        chk("wb_fault", 32'(mem_fault), 32'(e.fault));
        if (!e.bubble) begin
          chk("wb_rd", 32'(mem_rd), 32'(e.rd));
          chk("wb_alu", mem_alu_result, e.alu);
          chk("wb_rdata", mem_read_data, e.rdata);
          chk("wb_pc4", mem_instr_addr_plus, e.pc4);
        end
      end
    end
    pend = mon_en && rst_n && !mem_stall;
  end

  task automatic issue(input string tag, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [2:0] f3, input logic we, input logic [1:0] rsrc,
                       input logic [4:0] rd, input logic wen, input logic [31:0] pc4,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                       input int exp_stalls, input logic exp_req, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input wb_t exp);
    int stalls = 0, nreq = 0, nwait = 0;
    bit req_seen = 0, granted = 0, done = 0;
    execute_alu_result        = alu;
    execute_wr_datamem_data   = sd;
    execute_funct3            = f3;
    execute_datamem_wr_enable = we;
    execute_result_src        = rsrc;
    execute_rd                = rd;
    execute_regfile_wr_enable = wen;
    execute_instr_addr_plus   = pc4;
    dmem_rdata                = rdata;
    sb.push_back(exp);
    for (int c = 0; c < 48 && !done; c++) begin
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (dmem_req) begin
        req_seen = 1'b1;
        chk({tag, "_addr"}, dmem_addr, {alu[31:2], 2'b00});
        chk({tag, "_we"}, 32'(dmem_we), 32'(we));
        if (we) begin
          chk({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
          chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
        end
        if (nreq == gnt_dly) begin
          dmem_gnt = 1'b1;
          if (!we) granted = 1'b1;
        end
        nreq++;
      end else if (granted) begin
        if (nwait == rv_dly) dmem_rvalid = 1'b1;
        nwait++;
      end
      @(negedge clk);
      if (!mem_stall) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    chk({tag, "_bounded"}, 32'(done), 32'd1);
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    chk({tag, "_req"}, 32'(req_seen), 32'(exp_req));
  endtask

  task automatic nop(input string tag);
    issue(tag, '0, '0, 3'b000, 1'b0, 2'b00, 5'd0, 1'b0, '0, -1, -1, '0, 0, 1'b0, '0, '0,
          mk(5'd0, 1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0));
  endtask

  initial begin
    rst_n = 1'b0;
    execute_alu_result = '0; execute_wr_datamem_data = '0; execute_funct3 = '0;
    execute_datamem_wr_enable = 1'b0; execute_result_src = '0; execute_rd = '0;
    execute_regfile_wr_enable = 1'b0; execute_instr_addr_plus = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_wen", 32'(mem_regfile_wr_enable), 0);
    chk("rst_alu", mem_alu_result, 0);
    chk("rst_rdata", mem_read_data, 0);
    chk("rst_fault", 32'(mem_fault), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    issue("add", 32'h1234, '0, 3'b000, 1'b0, 2'b00, 5'd5, 1'b1, 32'h44, -1, -1, '0, 0, 1'b0, '0, '0,
          mk(5'd5, 1'b1, 2'b00, 32'h1234, '0, 32'h44, 1'b0, 1'b0));
    issue("sb", 32'h103, 32'h000000AB, 3'b000, 1'b1, 2'b00, 5'd0, 1'b0, 32'h48, 2, -1, '0,
          3, 1'b1, 4'b1000, 32'hABABABAB, mk(5'd0, 1'b0, 2'b00, 32'h103, '0, 32'h48, 1'b0, 1'b0));
    issue("lb", 32'h102, '0, 3'b000, 1'b0, 2'b01, 5'd7, 1'b1, 32'h4C, 0, 0, 32'h00F00000,
          2, 1'b1, '0, '0, mk(5'd7, 1'b1, 2'b01, 32'h102, 32'hFFFFFFF0, 32'h4C, 1'b0, 1'b0));
    issue("lbu", 32'h102, '0, 3'b100, 1'b0, 2'b01, 5'd7, 1'b1, 32'h50, 0, 0, 32'h00F00000,
          2, 1'b1, '0, '0, mk(5'd7, 1'b1, 2'b01, 32'h102, 32'h000000F0, 32'h50, 1'b0, 1'b0));
    issue("lb0", 32'h100, '0, 3'b000, 1'b0, 2'b01, 5'd3, 1'b1, 32'h54, 0, 0, 32'h00000080,
          2, 1'b1, '0, '0, mk(5'd3, 1'b1, 2'b01, 32'h100, 32'hFFFFFF80, 32'h54, 1'b0, 1'b0));
    issue("lbu3", 32'h103, '0, 3'b100, 1'b0, 2'b01, 5'd4, 1'b1, 32'h58, 0, 0, 32'h7F000000,
          2, 1'b1, '0, '0, mk(5'd4, 1'b1, 2'b01, 32'h103, 32'h0000007F, 32'h58, 1'b0, 1'b0));
    issue("lh", 32'h102, '0, 3'b001, 1'b0, 2'b01, 5'd6, 1'b1, 32'h5C, 0, 0, 32'h80010000,
          2, 1'b1, '0, '0, mk(5'd6, 1'b1, 2'b01, 32'h102, 32'hFFFF8001, 32'h5C, 1'b0, 1'b0));
    issue("lhu", 32'h100, '0, 3'b101, 1'b0, 2'b01, 5'd6, 1'b1, 32'h60, 0, 0, 32'h12348765,
          2, 1'b1, '0, '0, mk(5'd6, 1'b1, 2'b01, 32'h100, 32'h00008765, 32'h60, 1'b0, 1'b0));
    issue("lw", 32'h200, '0, 3'b010, 1'b0, 2'b01, 5'd10, 1'b1, 32'h64, 1, 2, 32'hDEADBEEF,
          5, 1'b1, '0, '0, mk(5'd10, 1'b1, 2'b01, 32'h200, 32'hDEADBEEF, 32'h64, 1'b0, 1'b0));
    issue("sh", 32'h106, 32'h1234BEEF, 3'b001, 1'b1, 2'b00, 5'd0, 1'b0, 32'h68, 0, -1, '0,
          1, 1'b1, 4'b1100, 32'hBEEFBEEF, mk(5'd0, 1'b0, 2'b00, 32'h106, '0, 32'h68, 1'b0, 1'b0));
    issue("sw", 32'h10, 32'hCAFEF00D, 3'b010, 1'b1, 2'b00, 5'd0, 1'b0, 32'h6C, 1, -1, '0,
          2, 1'b1, 4'b1111, 32'hCAFEF00D, mk(5'd0, 1'b0, 2'b00, 32'h10, '0, 32'h6C, 1'b0, 1'b0));
    issue("pc4", 32'h55, '0, 3'b000, 1'b0, 2'b10, 5'd1, 1'b1, 32'h200, -1, -1, '0, 0, 1'b0, '0, '0,
          mk(5'd1, 1'b1, 2'b10, 32'h55, '0, 32'h200, 1'b0, 1'b0));
    issue("mis_lh", 32'h101, '0, 3'b001, 1'b0, 2'b01, 5'd8, 1'b1, 32'h70, 0, 0, 32'h11111111,
          0, 1'b0, '0, '0, mk(5'd0, 1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b1));
    nop("after_mis_lh");
    issue("mis_sw", 32'h102, 32'h5A5A5A5A, 3'b010, 1'b1, 2'b00, 5'd0, 1'b0, 32'h74, 0, -1, '0,
          0, 1'b0, '0, '0, mk(5'd0, 1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b1));
    nop("after_mis_sw");
    issue("tmo", 32'h400, '0, 3'b010, 1'b0, 2'b01, 5'd11, 1'b1, 32'h78, 0, -1, 32'h99999999,
          16, 1'b1, '0, '0, mk(5'd0, 1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b1));
    issue("after_tmo", 32'h77, '0, 3'b000, 1'b0, 2'b00, 5'd2, 1'b1, 32'h7C, -1, -1, '0, 0, 1'b0, '0, '0,
          mk(5'd2, 1'b1, 2'b00, 32'h77, '0, 32'h7C, 1'b0, 1'b0));
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);

    // Reset while a load waits for read data; the late rvalid must be dropped
    @(posedge clk); #1;
    execute_alu_result = 32'h300; execute_funct3 = 3'b010; execute_result_src = 2'b01;
    execute_rd = 5'd9; execute_regfile_wr_enable = 1'b1; dmem_rdata = 32'h55555555;
    @(negedge clk);
    chk("rw_stall_idle", 32'(mem_stall), 1);
    @(posedge clk); #1;
    chk("rw_req", 32'(dmem_req), 1);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chk("rw_wait_stall", 32'(mem_stall), 1);
    rst_n = 1'b0;
    execute_alu_result = '0; execute_funct3 = '0; execute_result_src = '0;
    execute_rd = '0; execute_regfile_wr_enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("rw_req_dropped", 32'(dmem_req), 0);
    chk("rw_stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("rw_wen", 32'(mem_regfile_wr_enable), 0);
    chk("rw_rdata", mem_read_data, 0);
    chk("rw_rd", 32'(mem_rd), 0);
    chk("rw_rsrc", 32'(mem_result_src), 0);
    chk("rw_fault", 32'(mem_fault), 0);
    chk("rw_req_idle", 32'(dmem_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
